// File: rtl/t_latch_design.sv
// t_latch_design: bank of WIDTH independent edge-triggered toggle cells with complementary outputs
//   T     : per-bit toggle command, sampled on the rising clk edge
//   clk   : clock, state updates on the rising edge only
//   Q     : stored state
//   Qbar  : bitwise complement of Q, derived from the state register only
//   rst_n : asynchronous active-low reset, loads RESET_VAL
module t_latch_design #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] T,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    input  logic             rst_n
);
    logic [WIDTH-1:0] qr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) qr <= RESET_VAL;
        else        qr <= qr ^ T;
    assign Q    = qr;
    assign Qbar = ~qr;
endmodule

// File: tb/tb_t_latch_design.sv
// tb_t_latch_design: directed self-checking bench for a 1-bit and a 4-bit toggle bank
module tb_t_latch_design;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t1 = 1'b1;
    logic [3:0] t4 = 4'b1111;
    logic       q1, qb1;
    logic [3:0] q4, qb4;
    int checks = 0;
    int errors = 0;

    t_latch_design #(.WIDTH(1)) dut1 (.T(t1), .clk(clk), .Q(q1), .Qbar(qb1), .rst_n(rst_n));
    t_latch_design #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (.T(t4), .clk(clk), .Q(q4), .Qbar(qb4), .rst_n(rst_n));

    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (q1 !== 1'b0) begin errors++; $display("FAIL reset_q1 got %b want 0", q1); end
            checks++; if (qb1 !== 1'b1) begin errors++; $display("FAIL reset_qb1 got %b want 1", qb1); end
            checks++; if (q4 !== 4'b1010) begin errors++; $display("FAIL reset_q4 got %b want 1010", q4); end
            checks++; if (qb4 !== 4'b0101) begin errors++; $display("FAIL reset_qb4 got %b want 0101", qb4); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL release_q1 got %b want 1", q1); end
        checks++; if (q4 !== 4'b0101) begin errors++; $display("FAIL release_q4 got %b want 0101", q4); end
        t1 = 1'b0; t4 = 4'b0000;
    endtask

    task automatic test_basic;
        logic [3:0] tv = 4'b1010;
        logic [3:0] qe = 4'b0110;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t1 = tv[i];
            @(posedge clk); #1;
            checks++; if (q1 !== qe[i]) begin errors++; $display("FAIL basic_q%0d got %b want %b", i, q1, qe[i]); end
            checks++; if (qb1 !== ~qe[i]) begin errors++; $display("FAIL basic_qb%0d got %b want %b", i, qb1, ~qe[i]); end
            t1 = ~t1;
            @(negedge clk);
            checks++; if (q1 !== qe[i]) begin errors++; $display("FAIL basic_midT%0d got %b want %b", i, q1, qe[i]); end
        end
        t1 = 1'b0;
    endtask

    task automatic test_hold;
        t1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL hold_setup got %b want 1", q1); end
        t1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (q1 !== 1'b1 || qb1 !== 1'b0) begin errors++; $display("FAIL hold_%0d got q=%b qb=%b want q=1 qb=0", i, q1, qb1); end
        end
    endtask

    task automatic test_toggle;
        logic e;
        t1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (q1 !== 1'b0) begin errors++; $display("FAIL toggle_setup got %b want 0", q1); end
        for (int i = 0; i < 6; i++) begin
            e = (i % 2 == 0);
            @(posedge clk); #1;
            checks++; if (q1 !== e || qb1 !== ~e) begin errors++; $display("FAIL toggle_%0d got q=%b qb=%b want q=%b", i, q1, qb1, e); end
            #3;
            checks++; if (q1 !== e) begin errors++; $display("FAIL toggle_high_%0d got %b want %b", i, q1, e); end
        end
        t1 = 1'b0;
    endtask

    task automatic test_async_reset;
        t1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL async_setup got %b want 1", q1); end
        t1 = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (q1 !== 1'b0 || qb1 !== 1'b1) begin errors++; $display("FAIL async_q1 got q=%b qb=%b want q=0 qb=1", q1, qb1); end
        checks++; if (q4 !== 4'b1010) begin errors++; $display("FAIL async_q4 got %b want 1010", q4); end
        @(negedge clk); rst_n = 1'b1; t1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL async_after got %b want 1", q1); end
        t1 = 1'b0;
    endtask

    task automatic test_multibit;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; t4 = 4'b0110;
        @(posedge clk); #1;
        checks++; if (q4 !== 4'b1100) begin errors++; $display("FAIL multi_q got %b want 1100", q4); end
        checks++; if (qb4 !== 4'b0011) begin errors++; $display("FAIL multi_qb got %b want 0011", qb4); end
        t4 = 4'b0000;
        @(posedge clk); #1;
        checks++; if (q4 !== 4'b1100) begin errors++; $display("FAIL multi_hold got %b want 1100", q4); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_toggle;
        test_async_reset;
        test_multibit;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
